// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit.
// Radix-2: 32 shift-add or restoring shift-subtract steps, then a sign-fix step.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_control,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_op_div;
  logic        r_neg_lo;
  logic        r_neg_hi;
  logic [31:0] r_a;
  logic [63:0] r_p;
  logic        r_busy;
  logic        r_done;
  logic        r_dbz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_signed;
  logic        w_s1;
  logic        w_s2;
  logic [31:0] w_m1;
  logic [31:0] w_m2;
  logic [32:0] w_madd;
  logic [32:0] w_rsh;
  logic [32:0] w_rdiff;
  logic [63:0] w_prod_n;
  logic [31:0] w_q_n;
  logic [31:0] w_r_n;

  assign w_signed = ~md_control[0];
  assign w_s1     = w_signed & op1[31];
  assign w_s2     = w_signed & op2[31];
  assign w_m1     = w_s1 ? (~op1 + 32'd1) : op1;
  assign w_m2     = w_s2 ? (~op2 + 32'd1) : op2;

  // Multiply: r_p = {partial, multiplier}; divide: r_p = {remainder, quotient}
  assign w_madd   = {1'b0, r_p[63:32]}
                  + (r_p[0] ? {1'b0, r_a} : 33'd0);
  assign w_rsh    = {r_p[63:32], r_p[31]};
  assign w_rdiff  = w_rsh - {1'b0, r_a};

  assign w_prod_n = ~r_p + 64'd1;
  assign w_q_n    = ~r_p[31:0] + 32'd1;
  assign w_r_n    = ~r_p[63:32] + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_op_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_a      <= 32'd0;
      r_p      <= 64'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (start) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_cnt    <= 6'd0;
            r_op_div <= md_control[1];
            r_neg_lo <= w_s1 ^ w_s2;
            r_neg_hi <= w_s1;
            if (md_control[1]) begin
              r_a <= w_m2;
              r_p <= {32'd0, w_m1};
            end else begin
              r_a <= w_m1;
              r_p <= {32'd0, w_m2};
            end
          end else begin
            if (hi_we) r_hi <= wr_data;
            if (lo_we) r_lo <= wr_data;
          end
        end
        S_RUN: begin
          if (r_op_div && (r_a == 32'd0)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_dbz   <= 1'b1;
          end else begin
            if (r_op_div) begin
              if (!w_rdiff[32])
                r_p <= {w_rdiff[31:0], r_p[30:0], 1'b1};
              else
                r_p <= {w_rsh[31:0], r_p[30:0], 1'b0};
            end else begin
              r_p <= {w_madd, r_p[31:1]};
            end
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_op_div) begin
            r_lo <= r_neg_lo ? w_q_n : r_p[31:0];
            r_hi <= r_neg_hi ? w_r_n : r_p[63:32];
          end else begin
            {r_hi, r_lo} <= r_neg_lo ? w_prod_n : r_p;
          end
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: transaction-level model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  md_control;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .md_control(md_control),
    .op1(op1),
    .op2(op2),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] c,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      2'b00: r = sa * sb;
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: begin
        q  = sa / sb;
        rm = sa % sb;
        r  = {rm[31:0], q[31:0]};
      end
      default: r = {a % b, a / b};
    endcase
    return r;
  endfunction

  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_dbz = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_left = 0;
  logic        p_dbz = 1'b0;
  logic [63:0] p_res = 64'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_dbz  = p_dbz;
          if (!p_dbz) begin
            m_hi = p_res[63:32];
            m_lo = p_res[31:0];
          end
        end
      end else if (start) begin
        m_busy = 1'b1;
        p_dbz  = md_control[1] && (op2 == 32'd0);
        m_left = p_dbz ? 1 : 33;
        if (!p_dbz) p_res = ref_op(md_control, op1, op2);
      end else begin
        if (hi_we) m_hi = wr_data;
        if (lo_we) m_lo = wr_data;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("dbz", {31'd0, div_by_zero}, {31'd0, m_dbz});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // Called at a negedge; start is sampled at the next rising edge (E0).
  task automatic run_op(input string nm, input logic [1:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input logic ed, input int lat);
    int k;
    k = 0;
    start = 1'b1;
    md_control = c;
    op1 = a;
    op2 = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
    check({nm, " latency"}, k, lat);
    if (k != 0) begin
      check({nm, " hi"}, hi, eh);
      check({nm, " lo"}, lo, el);
      check({nm, " dbz"}, {31'd0, div_by_zero}, {31'd0, ed});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    reset = 1'b1;
    start = 1'b0;
    md_control = 2'b00;
    op1 = 32'd0;
    op2 = 32'd0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wr_data = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mult 7*-3", 2'b00, 32'd7, 32'hFFFFFFFD,
           32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
    run_op("multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    run_op("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    run_op("div ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
           32'h00000000, 32'h80000000, 1'b0, 33);
    run_op("divu 100/7", 2'b11, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 33);
    run_op("mult min*min", 2'b00, 32'h80000000, 32'h80000000,
           32'h40000000, 32'h00000000, 1'b0, 33);
    run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE,
           32'd1, 32'hFFFFFFFD, 1'b0, 33);
    run_op("divu max/1", 2'b11, 32'hFFFFFFFF, 32'd1,
           32'd0, 32'hFFFFFFFF, 1'b0, 33);
    run_op("multu x*2", 2'b01, 32'hFFFFFFFF, 32'd2,
           32'd1, 32'hFFFFFFFE, 1'b0, 33);
    run_op("multu x*0", 2'b01, 32'h12345678, 32'd0,
           32'd0, 32'd0, 1'b0, 33);

    hi_we = 1'b1;
    lo_we = 1'b1;
    wr_data = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthi", hi, 32'h12345678);
    check("mtlo", lo, 32'h12345678);

    run_op("divu by 0", 2'b11, 32'd100, 32'd0,
           32'h12345678, 32'h12345678, 1'b1, 1);
    run_op("div by 0", 2'b10, 32'hFFFFFFFB, 32'd0,
           32'h12345678, 32'h12345678, 1'b1, 1);

    // mtlo while busy must be dropped
    start = 1'b1;
    md_control = 2'b00;
    op1 = 32'd3;
    op2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    lo_we = 1'b1;
    wr_data = 32'hDEADBEEF;
    @(negedge clk);
    lo_we = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        nd = 1;
        break;
      end
    end
    check("busy wr done", nd, 1);
    check("busy wr lo", lo, 32'd15);
    check("busy wr hi", hi, 32'd0);

    // Abort: start+mthi at E10 ignored, reset at E15
    start = 1'b1;
    md_control = 2'b01;
    op1 = 32'h00010001;
    op2 = 32'h00020002;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    hi_we = 1'b1;
    md_control = 2'b11;
    op2 = 32'd0;
    wr_data = 32'hAAAA5555;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    check("E10 busy", {31'd0, busy}, 32'd1);
    check("E10 hi", hi, 32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("abort no done", nd, 0);

    run_op("post mult", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'd0, 32'd1, 1'b0, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
